serial_subtractor: RTL and testbench

- Multi-cycle unsigned subtract-with-borrow: y = a - b - bin over WIDTH bits, processed DIGIT bits per clock, LSB digit first.
- Inverse-direction companion to the team's combinational 16-bit add-with-carry datapath.
- Used where area matters more than latency.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: unsigned a - b - bin over WIDTH bits, DIGIT bits per
// clock, least-significant digit first. Operands arrive on a valid/ready
// handshake and the result leaves on a second one.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one digit of the difference per cycle
// DONE  | result presented, out_valid=1 until out_ready
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             bout,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject digit sizes that do not tile the operand exactly.
  generate
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 || DIGIT == 16) ||
        (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor: DIGIT must be 1/2/4/8/16 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              brw_q;
  logic [CW-1:0]     cnt_q;
  logic [DIGIT-1:0]  a_dig, b_dig;
  logic [DIGIT:0]    diff;
  logic [WIDTH-1:0]  y_next;
  logic              last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Current digit difference; the extra top bit of diff is the borrow out.
  always_comb begin
    a_dig  = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig  = b_q[cnt_q*DIGIT +: DIGIT];
    diff   = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_q};
    y_next = y;
    y_next[cnt_q*DIGIT +: DIGIT] = diff[DIGIT-1:0];
    last   = (cnt_q == CW'(NDIG - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE returns to IDLE before new operands are taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand capture and digit-serial datapath; flags latch on the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      brw_q <= 1'b0;
      cnt_q <= '0;
      y     <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            brw_q <= bin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          y     <= y_next;
          brw_q <= diff[DIGIT];
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            bout <= diff[DIGIT];
            zero <= (y_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a DIGIT=1 and a DIGIT=4 instance driven by
// directed vectors with hand-computed results, then random vectors checked
// against a - b - bin computed in the bench.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[2], ir[2], ov[2], ordy[2], bin_i[2], bo[2], zr[2];
  logic [15:0] a_i[2], b_i[2], yv[2];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_i[0]), .b(b_i[0]), .bin(bin_i[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .y(yv[0]), .bout(bo[0]), .zero(zr[0])
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_i[1]), .b(b_i[1]), .bin(bin_i[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .y(yv[1]), .bout(bo[1]), .zero(zr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full transaction on instance s. With chain set, out_ready is left
  // high and the call returns so the next call raises in_valid in DONE.
  task automatic op(input int s, input logic [15:0] av, input logic [15:0] bv,
                    input logic bi, input logic [15:0] ey, input logic eb,
                    input logic ez, input int hold, input bit chain, input string tag);
    int k;
    a_i[s] = av; b_i[s] = bv; bin_i[s] = bi; iv[s] = 1'b1;
    k = 0;
    while (!ir[s] && k < 40) begin
      @(posedge clk); #1;
      ordy[s] = 1'b0;
      k++;
    end
    chk({tag, "_ready_before_accept"}, {31'd0, ir[s]}, 32'd1);
    @(posedge clk); #1;
    iv[s] = 1'b0;
    a_i[s] = 16'($urandom); b_i[s] = 16'($urandom); bin_i[s] = 1'($urandom);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ov[s] && k < 40);
    chk({tag, "_latency"}, k, (s == 0) ? 32'd16 : 32'd4);
    chk({tag, "_y"}, {16'd0, yv[s]}, {16'd0, ey});
    chk({tag, "_bout"}, {31'd0, bo[s]}, {31'd0, eb});
    chk({tag, "_zero"}, {31'd0, zr[s]}, {31'd0, ez});
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        iv[s] = 1'b1; a_i[s] = 16'h5555; b_i[s] = 16'h0000; bin_i[s] = 1'b0;
      end else begin
        iv[s] = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, ov[s]}, 32'd1);
      chk({tag, "_hold_inready"}, {31'd0, ir[s]}, 32'd0);
      chk({tag, "_hold_y"}, {16'd0, yv[s]}, {16'd0, ey});
      chk({tag, "_hold_flags"}, {30'd0, bo[s], zr[s]}, {30'd0, eb, ez});
    end
    iv[s] = 1'b0;
    ordy[s] = 1'b1;
    if (!chain) begin
      @(posedge clk); #1;
      ordy[s] = 1'b0;
      chk({tag, "_release_valid"}, {31'd0, ov[s]}, 32'd0);
      chk({tag, "_release_inready"}, {31'd0, ir[s]}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] av, bv, ey;
    logic        bi, eb;
    int          k;

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b0; a_i[s] = '0; b_i[s] = '0; bin_i[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_inready", {31'd0, ir[s]}, 32'd1);
      chk("reset_outvalid", {31'd0, ov[s]}, 32'd0);
      chk("reset_y", {16'd0, yv[s]}, 32'd0);
      chk("reset_flags", {30'd0, bo[s], zr[s]}, 32'd0);
    end
    #3 rst_n = 1'b1;

    op(0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0, "basic");
    op(0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, "underflow");
    op(0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, "eq_bin");
    op(0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, "all_zero");
    op(0, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 5, 1'b1, "hold");
    op(0, 16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0, 0, 1'b0, "after_hold");

    // Asynchronous reset in the middle of RUN.
    a_i[0] = 16'hAAAA; b_i[0] = 16'h5555; bin_i[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("midrst_running", {31'd0, ir[0]}, 32'd0);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_outvalid", {31'd0, ov[0]}, 32'd0);
    chk("midrst_y", {16'd0, yv[0]}, 32'd0);
    chk("midrst_inready", {31'd0, ir[0]}, 32'd1);
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    chk("midrst_release_inready", {31'd0, ir[0]}, 32'd1);
    // No stale result may appear after reset release.
    k = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov[0]) k++;
    end
    chk("midrst_no_partial", k, 32'd0);
    op(0, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 0, 1'b0, "post_reset");

    op(1, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0, "d4_basic");
    op(1, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 3, 1'b0, "d4_eq_bin");

    for (int i = 0; i < 1000; i++) begin
      for (int s = 0; s < 2; s++) begin
        av = 16'($urandom);
        bv = (i % 8 == 0) ? av : 16'($urandom);
        bi = 1'($urandom_range(0, 1));
        {eb, ey} = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        op(s, av, bv, bi, ey, eb, (ey == 16'd0), $urandom_range(0, 3), 1'b0,
           (s == 0) ? "rand_d1" : "rand_d4");
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
